// File: rtl/mc_ctrl_fsm_if.sv
// Control bundle between the multicycle control FSM, the datapath and the
// variable-latency functional unit.
interface mc_ctrl_fsm_if #(
    parameter int CNT_W = 32
);
    // Decoded instruction fields and functional-unit handshake
    logic [1:0]       Op;
    logic [5:0]       Funct;
    logic             MultiCycle;
    logic             LongMul;
    logic             NoWrite;
    logic             ExDone;

    // Datapath controls
    logic             IRWrite;
    logic             AdrSrc;
    logic             ALUSrcA;
    logic             NextPC;
    logic             RegW;
    logic             MemW;
    logic             Branch;
    logic             ALUOp;
    logic             RegWHi;
    logic [1:0]       ALUSrcB;
    logic [1:0]       ResultSrc;
    logic             ExStart;
    logic             Busy;
    logic             Halted;
    logic [CNT_W-1:0] InstrCount;

    modport master (
        input  Op, Funct, MultiCycle, LongMul, NoWrite, ExDone,
        output IRWrite, AdrSrc, ALUSrcA, NextPC, RegW, MemW, Branch, ALUOp,
               RegWHi, ALUSrcB, ResultSrc, ExStart, Busy, Halted, InstrCount
    );

    modport slave (
        output Op, Funct, MultiCycle, LongMul, NoWrite, ExDone,
        input  IRWrite, AdrSrc, ALUSrcA, NextPC, RegW, MemW, Branch, ALUOp,
               RegWHi, ALUSrcB, ResultSrc, ExStart, Busy, Halted, InstrCount
    );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multicycle control FSM: fetch/decode/execute/memory/writeback sequencing with
// a variable-latency execute handshake, watchdog trap and retired-instruction count.
module mc_ctrl_fsm #(
    parameter int TIMEOUT        = 255,
    parameter int HI_WB_SEPARATE = 1,
    parameter int CNT_W          = 32
) (
    input  logic          clk,
    input  logic          reset,
    mc_ctrl_fsm_if.master ctrl
);
    localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam bit WD_ON  = (TIMEOUT != 0);
    localparam bit HI_SEP = (HI_WB_SEPARATE != 0);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WD_ON ? TIMEOUT - 1 : 0);

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_EXWAIT,
        S_ALUWB,
        S_ALUWBHI,
        S_BRANCH,
        S_TRAP
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              imm_q;
    logic [CNT_W-1:0]  instr_count;
    logic              wd_expire;

    // A result arriving in the last allowed cycle beats the watchdog.
    assign wd_expire = WD_ON && (wait_cnt == WAIT_LAST) && !ctrl.ExDone;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Holding the counter at zero outside EXWAIT clears it on every entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (state != S_EXWAIT) begin
            wait_cnt <= '0;
        end else if (!ctrl.ExDone) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // I bit captured at execute so EXWAIT keeps the same ALUSrcB selection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            imm_q <= 1'b0;
        end else if (state == S_EXECR || state == S_EXECI) begin
            imm_q <= (state == S_EXECI);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_count <= '0;
        end else if (next_state == S_FETCH && state != S_FETCH) begin
            instr_count <= instr_count + 1'b1;
        end
    end

    assign ctrl.InstrCount = instr_count;

    // NOTE: every output and next_state gets a default before the case so no
    // path through the block can leave a value unassigned and infer a latch.
    always_comb begin
        next_state     = state;
        ctrl.IRWrite   = 1'b0;
        ctrl.AdrSrc    = 1'b0;
        ctrl.ALUSrcA   = 1'b0;
        ctrl.NextPC    = 1'b0;
        ctrl.RegW      = 1'b0;
        ctrl.MemW      = 1'b0;
        ctrl.Branch    = 1'b0;
        ctrl.ALUOp     = 1'b0;
        ctrl.RegWHi    = 1'b0;
        ctrl.ALUSrcB   = 2'b00;
        ctrl.ResultSrc = 2'b00;
        ctrl.ExStart   = 1'b0;
        ctrl.Busy      = 1'b0;
        ctrl.Halted    = 1'b0;

        case (state)
            S_FETCH: begin
                ctrl.IRWrite   = 1'b1;
                ctrl.NextPC    = 1'b1;
                ctrl.ALUSrcA   = 1'b1;
                ctrl.ALUSrcB   = 2'b10;
                ctrl.ResultSrc = 2'b10;
                next_state     = S_DECODE;
            end

            S_DECODE: begin
                ctrl.ALUSrcA   = 1'b1;
                ctrl.ALUSrcB   = 2'b10;
                ctrl.ResultSrc = 2'b10;
                case (ctrl.Op)
                    2'b00:   next_state = ctrl.Funct[5] ? S_EXECI : S_EXECR;
                    2'b01:   next_state = S_MEMADR;
                    2'b10:   next_state = S_BRANCH;
                    default: next_state = S_TRAP;
                endcase
            end

            S_MEMADR: begin
                ctrl.ALUSrcB = 2'b01;
                next_state   = ctrl.Funct[0] ? S_MEMREAD : S_MEMWRITE;
            end

            S_MEMREAD: begin
                ctrl.AdrSrc = 1'b1;
                next_state  = S_MEMWB;
            end

            S_MEMWB: begin
                ctrl.ResultSrc = 2'b01;
                ctrl.RegW      = 1'b1;
                next_state     = S_FETCH;
            end

            S_MEMWRITE: begin
                ctrl.AdrSrc = 1'b1;
                ctrl.MemW   = 1'b1;
                next_state  = S_FETCH;
            end

            S_EXECR, S_EXECI: begin
                ctrl.ALUOp   = 1'b1;
                ctrl.ALUSrcB = (state == S_EXECI) ? 2'b01 : 2'b00;
                if (ctrl.MultiCycle) begin
                    ctrl.ExStart = 1'b1;
                    next_state   = S_EXWAIT;
                end else if (ctrl.NoWrite) begin
                    next_state = S_FETCH;
                end else begin
                    next_state = S_ALUWB;
                end
            end

            S_EXWAIT: begin
                ctrl.ALUOp   = 1'b1;
                ctrl.ALUSrcB = {1'b0, imm_q};
                ctrl.Busy    = 1'b1;
                if (ctrl.ExDone) begin
                    next_state = ctrl.NoWrite ? S_FETCH : S_ALUWB;
                end else if (wd_expire) begin
                    next_state = S_TRAP;
                end
            end

            S_ALUWB: begin
                ctrl.RegW      = 1'b1;
                ctrl.ResultSrc = 2'b00;
                ctrl.RegWHi    = !HI_SEP && ctrl.LongMul;
                next_state     = (HI_SEP && ctrl.LongMul) ? S_ALUWBHI : S_FETCH;
            end

            S_ALUWBHI: begin
                ctrl.RegWHi = 1'b1;
                next_state  = S_FETCH;
            end

            S_BRANCH: begin
                ctrl.ALUSrcB   = 2'b01;
                ctrl.ResultSrc = 2'b10;
                ctrl.Branch    = 1'b1;
                next_state     = S_FETCH;
            end

            S_TRAP: begin
                ctrl.Halted = 1'b1;
                next_state  = S_TRAP;
            end

            default: begin
                next_state = S_FETCH;
            end
        endcase
    end
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench: three parameterisations of mc_ctrl_fsm checked every
// cycle against an instruction-level trace model, one DUT active at a time.
module tb_mc_ctrl_fsm;
    typedef enum int {
        P_FETCH, P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWB, P_MEMWRITE,
        P_EXECR, P_EXECI, P_EXWAIT, P_ALUWB, P_ALUWBHI, P_BRANCH, P_TRAP
    } ph_e;

    typedef struct packed {
        logic        ir_write;
        logic        adr_src;
        logic        alu_src_a;
        logic        next_pc;
        logic        reg_w;
        logic        mem_w;
        logic        branch;
        logic        alu_op;
        logic        reg_w_hi;
        logic [1:0]  alu_src_b;
        logic [1:0]  result_src;
        logic        ex_start;
        logic        busy;
        logic        halted;
        logic [31:0] count;
    } obs_t;

    // Per-DUT configuration: A=(4,1,4) B=(0,0,32) C=(255,1,32)
    int cfg_timeout [3] = '{4, 0, 255};
    int cfg_hisep   [3] = '{1, 0, 1};
    int cfg_cntw    [3] = '{4, 32, 32};

    logic       clk = 1'b0;
    logic [2:0] rst = 3'b111;
    logic [1:0] op = '0;
    logic [5:0] funct = '0;
    logic       mc = 1'b0, lm = 1'b0, nw = 1'b0, ex_done = 1'b0;
    int         sel = 0;

    int n_pass = 0;
    int n_total = 0;

    obs_t  exp_o;
    ph_e   exp_ph = P_FETCH;
    logic  exp_on = 1'b0;
    logic [31:0] m_count = '0;

    always #5 clk = ~clk;

    mc_ctrl_fsm_if #(.CNT_W(4))  ifa ();
    mc_ctrl_fsm_if #(.CNT_W(32)) ifb ();
    mc_ctrl_fsm_if #(.CNT_W(32)) ifc ();

    assign ifa.Op = op;  assign ifa.Funct = funct;  assign ifa.MultiCycle = mc;
    assign ifa.LongMul = lm;  assign ifa.NoWrite = nw;  assign ifa.ExDone = ex_done;
    assign ifb.Op = op;  assign ifb.Funct = funct;  assign ifb.MultiCycle = mc;
    assign ifb.LongMul = lm;  assign ifb.NoWrite = nw;  assign ifb.ExDone = ex_done;
    assign ifc.Op = op;  assign ifc.Funct = funct;  assign ifc.MultiCycle = mc;
    assign ifc.LongMul = lm;  assign ifc.NoWrite = nw;  assign ifc.ExDone = ex_done;

    mc_ctrl_fsm #(.TIMEOUT(4), .HI_WB_SEPARATE(1), .CNT_W(4)) dut_a (
        .clk(clk), .reset(rst[0]), .ctrl(ifa.master));
    mc_ctrl_fsm #(.TIMEOUT(0), .HI_WB_SEPARATE(0), .CNT_W(32)) dut_b (
        .clk(clk), .reset(rst[1]), .ctrl(ifb.master));
    mc_ctrl_fsm #(.TIMEOUT(255), .HI_WB_SEPARATE(1), .CNT_W(32)) dut_c (
        .clk(clk), .reset(rst[2]), .ctrl(ifc.master));

    obs_t oa, ob, oc, o;
    assign oa = {ifa.IRWrite, ifa.AdrSrc, ifa.ALUSrcA, ifa.NextPC, ifa.RegW, ifa.MemW,
                 ifa.Branch, ifa.ALUOp, ifa.RegWHi, ifa.ALUSrcB, ifa.ResultSrc,
                 ifa.ExStart, ifa.Busy, ifa.Halted, 32'(ifa.InstrCount)};
    assign ob = {ifb.IRWrite, ifb.AdrSrc, ifb.ALUSrcA, ifb.NextPC, ifb.RegW, ifb.MemW,
                 ifb.Branch, ifb.ALUOp, ifb.RegWHi, ifb.ALUSrcB, ifb.ResultSrc,
                 ifb.ExStart, ifb.Busy, ifb.Halted, 32'(ifb.InstrCount)};
    assign oc = {ifc.IRWrite, ifc.AdrSrc, ifc.ALUSrcA, ifc.NextPC, ifc.RegW, ifc.MemW,
                 ifc.Branch, ifc.ALUOp, ifc.RegWHi, ifc.ALUSrcB, ifc.ResultSrc,
                 ifc.ExStart, ifc.Busy, ifc.Halted, 32'(ifc.InstrCount)};

    always_comb begin
        case (sel)
            0:       o = oa;
            1:       o = ob;
            default: o = oc;
        endcase
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t dut=%0d)", name, act, req, $time, sel);
    endtask

    // Output table of each phase of an instruction.
    function automatic obs_t expect_for(ph_e ph, logic ibit, logic lmul, logic exst,
                                        int hisep, logic [31:0] cnt);
        obs_t e;
        e = '0;
        e.count = cnt;
        case (ph)
            P_FETCH:    begin e.ir_write = 1; e.next_pc = 1; e.alu_src_a = 1;
                              e.alu_src_b = 2'b10; e.result_src = 2'b10; end
            P_DECODE:   begin e.alu_src_a = 1; e.alu_src_b = 2'b10; e.result_src = 2'b10; end
            P_MEMADR:   e.alu_src_b = 2'b01;
            P_MEMREAD:  e.adr_src = 1;
            P_MEMWB:    begin e.result_src = 2'b01; e.reg_w = 1; end
            P_MEMWRITE: begin e.adr_src = 1; e.mem_w = 1; end
            P_EXECR:    begin e.alu_op = 1; e.alu_src_b = 2'b00; e.ex_start = exst; end
            P_EXECI:    begin e.alu_op = 1; e.alu_src_b = 2'b01; e.ex_start = exst; end
            P_EXWAIT:   begin e.alu_op = 1; e.alu_src_b = ibit ? 2'b01 : 2'b00; e.busy = 1; end
            P_ALUWB:    begin e.reg_w = 1; e.reg_w_hi = (hisep == 0) && lmul; end
            P_ALUWBHI:  e.reg_w_hi = 1;
            P_BRANCH:   begin e.alu_src_b = 2'b01; e.result_src = 2'b10; e.branch = 1; end
            P_TRAP:     e.halted = 1;
            default:    e = '0;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] cnt_mask();
        if (cfg_cntw[sel] >= 32) return 32'hFFFF_FFFF;
        return (32'd1 << cfg_cntw[sel]) - 32'd1;
    endfunction

    always @(negedge clk) begin
        if (exp_on) check($sformatf("cycle_%s", exp_ph.name()), 64'(o), 64'(exp_o));
    end

    // Runs one instruction from its FETCH cycle. w = EXWAIT cycles; ExDone
    // arrives on the last one when done_i, else the watchdog must fire.
    // stop >= 0 abandons the instruction at that cycle index (for reset tests).
    task automatic run_instr(input logic [1:0] op_i, input logic [5:0] funct_i,
                             input logic mc_i, input logic lm_i, input logic nw_i,
                             input int w, input bit done_i, input int stop,
                             output int len, output bit trapped);
        ph_e tr[$];
        int  hs;
        int  k;
        bit  is_exec;
        hs = cfg_hisep[sel];
        tr.push_back(P_FETCH);
        tr.push_back(P_DECODE);
        case (op_i)
            2'b01: begin
                tr.push_back(P_MEMADR);
                if (funct_i[0]) begin tr.push_back(P_MEMREAD); tr.push_back(P_MEMWB); end
                else tr.push_back(P_MEMWRITE);
            end
            2'b10: tr.push_back(P_BRANCH);
            2'b11: tr.push_back(P_TRAP);
            default: begin
                tr.push_back(funct_i[5] ? P_EXECI : P_EXECR);
                if (mc_i) begin
                    repeat (w) tr.push_back(P_EXWAIT);
                    if (!done_i) tr.push_back(P_TRAP);
                end
                if (tr[$] != P_TRAP && !nw_i) begin
                    tr.push_back(P_ALUWB);
                    if (lm_i && hs != 0) tr.push_back(P_ALUWBHI);
                end
            end
        endcase
        trapped = (tr[$] == P_TRAP);
        len = tr.size();
        if (trapped) repeat (3) tr.push_back(P_TRAP);

        op = op_i; funct = funct_i; mc = mc_i; lm = lm_i; nw = nw_i;
        k = 0;
        for (int i = 0; i < tr.size(); i++) begin
            if (stop >= 0 && i == stop) break;
            is_exec = (tr[i] == P_EXECR || tr[i] == P_EXECI);
            if (tr[i] == P_EXWAIT) begin
                k++;
                ex_done = done_i && (k == w);
            end else if (is_exec && mc_i) begin
                ex_done = 1'b0;
            end else begin
                ex_done = 1'($urandom_range(1, 0));
            end
            exp_o  = expect_for(tr[i], funct_i[5], lm_i, is_exec && mc_i, hs, m_count);
            exp_ph = tr[i];
            exp_on = 1'b1;
            @(posedge clk);
            #1;
        end
        exp_on  = 1'b0;
        ex_done = 1'b0;
        if (!trapped && (stop < 0 || stop >= tr.size())) m_count = (m_count + 1) & cnt_mask();
    endtask

    // Asserts reset mid-cycle and checks the asynchronous return to FETCH.
    task automatic do_reset(input string name);
        exp_on = 1'b0;
        #2;
        rst[sel] = 1'b1;
        #1;
        check(name, 64'(o), 64'(expect_for(P_FETCH, 1'b0, 1'b0, 1'b0, 0, 32'd0)));
        @(posedge clk);
        #1;
        rst[sel] = 1'b0;
        m_count = '0;
    endtask

    task automatic start_dut(input int s);
        sel = s;
        rst = 3'b111;
        @(posedge clk);
        #1;
        check($sformatf("reset_state_%0d", s), 64'(o),
              64'(expect_for(P_FETCH, 1'b0, 1'b0, 1'b0, 0, 32'd0)));
        rst[s]  = 1'b0;
        m_count = '0;
    endtask

    task automatic random_run(input int n);
        logic [1:0] r_op;
        int  lim, w, len, t;
        bit  done, trp;
        t = cfg_timeout[sel];
        for (int i = 0; i < n; i++) begin
            r_op = 2'($urandom_range(3, 0));
            if (r_op == 2'b11 && $urandom_range(3, 0) != 0) r_op = 2'b00;
            lim = (t != 0 && t < 6) ? t : 6;
            if (t != 0 && t <= 8 && $urandom_range(7, 0) == 0) begin
                w = t; done = 1'b0;
            end else begin
                w = $urandom_range(lim, 1); done = 1'b1;
            end
            run_instr(r_op, 6'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                      w, done, -1, len, trp);
            if (trp) do_reset("rand_trap_reset");
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1, "bench time limit expired");
    end

    initial begin
        int len;
        bit trp;

        // DUT A: TIMEOUT=4, HI_WB_SEPARATE=1, CNT_W=4
        start_dut(0);
        run_instr(2'b00, 6'b001000, 0, 0, 0, 0, 1, -1, len, trp);
        check("len_add", len, 4);
        check("count_after_add", o.count, 1);
        run_instr(2'b01, 6'b000001, 0, 0, 0, 0, 1, -1, len, trp);
        check("len_ldr", len, 5);
        run_instr(2'b01, 6'b000000, 0, 0, 0, 0, 1, -1, len, trp);
        check("len_str", len, 4);
        run_instr(2'b00, 6'b000000, 1, 1, 0, 3, 1, -1, len, trp);
        check("len_umull_sep", len, 8);
        run_instr(2'b00, 6'b010101, 0, 0, 1, 0, 1, -1, len, trp);
        check("len_cmp", len, 3);
        check("count_after_five", o.count, 5);
        run_instr(2'b00, 6'b000000, 1, 0, 0, 4, 1, -1, len, trp);
        check("len_done_last_wait", len, 8);
        check("no_trap_done_last", trp, 0);
        run_instr(2'b00, 6'b000000, 1, 0, 0, 4, 0, -1, len, trp);
        check("len_watchdog", len, 8);
        check("halted_stays", o.halted, 1);
        do_reset("reset_from_trap");
        check("count_after_trap_reset", o.count, 0);
        run_instr(2'b11, 6'b000000, 0, 0, 0, 0, 1, -1, len, trp);
        check("undef_traps", trp, 1);
        do_reset("reset_from_undef");
        run_instr(2'b00, 6'b100000, 1, 1, 0, 5, 1, 4, len, trp);
        do_reset("reset_mid_exwait");
        for (int i = 0; i < 16; i++) begin
            run_instr(2'b10, 6'($urandom), 0, 0, 0, 0, 1, -1, len, trp);
            if (i == 14) check("count_before_wrap", o.count, 15);
        end
        check("count_wrapped", o.count, 0);
        random_run(80);

        // DUT B: watchdog off, high result written alongside the low result
        start_dut(1);
        run_instr(2'b00, 6'b000000, 1, 1, 0, 3, 1, -1, len, trp);
        check("len_umull_joint", len, 7);
        run_instr(2'b00, 6'b100000, 1, 0, 0, 300, 1, -1, len, trp);
        check("len_long_wait", len, 304);
        random_run(80);

        // DUT C: default parameters
        start_dut(2);
        random_run(60);
        run_instr(2'b00, 6'b000000, 1, 0, 1, 255, 0, -1, len, trp);
        check("len_watchdog_255", len, 259);
        do_reset("reset_from_trap_255");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
